multicycle_alu: RTL and testbench
=================================

// Module: multicycle_alu
// PURPOSE
//  Parametrised, handshaked successor to the combinational execute-stage ALU of the RISC core.
//  Registers results and flags, runs MULT/MULTU as an iterative shift-add over WIDTH cycles,
//  and holds HI/LO in architectural registers. Sits between decode/operand fetch and data memory/branch logic.
// PARAMETERS
//  WIDTH    32  operand/result width (>=8, power of 2)
//  OP_W     7   opcode width: [6:4] group, [3:0] function
//  SHAMT_W  $clog2(WIDTH)  localparam; shift amount = in_b[SHAMT_W-1:0]
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        operation offered
//  in_ready     out  1        operation accepted when in_valid&in_ready
//  alu_op       in   OP_W     opcode (encodings in package)
//  in_a         in   WIDTH    operand 1
//  in_b         in   WIDTH    operand 2 / immediate / shift amount
//  out_valid    out  1        result valid, held until out_ready
//  out_ready    in   1        consumer takes result
//  alu_result   out  WIDTH    result (0 for MULT/MULTU)
//  zflag, signflag, carryflag, overflowflag  out 1 each  registered flags
//  illegal_op   out  1        opcode not decoded
//  hi_value, lo_value  out  WIDTH  HI/LO product registers
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; state IDLE; an in-flight multiply is discarded.
//  States: IDLE (in_ready=1), MUL (iterate, in_ready=0), HOLD (out_valid=1).
//  in_ready = (state==IDLE) | (state==HOLD & out_ready); back-to-back single-cycle ops run at 1/cycle.
//  Single-cycle ops: accept at edge N -> out_valid, result, flags at N+1.
//  MULT/MULTU: accept at N -> MUL for WIDTH cycles -> HOLD with out_valid at N+WIDTH+1.
//  Outputs stable while out_valid & !out_ready. Inputs are sampled only at acceptance.
//  Ops: ADD, ADDI, SUB: WIDTH+1-bit sum. carry = bit WIDTH; overflow = signed overflow.
//   SUB is a + ~b + 1; carry = no-borrow.
//  COMP/COMPI: -in_b; AND, XOR, OR: bitwise; SLL, SRL, SRA: shift in_a by SHAMT, SRA sign-fills.
//  LDADDR/STADDR: in_a + in_b, no carry/overflow.
//  Non-add ops force carry = overflow = 0. zflag = (result==0). signflag = result[WIDTH-1].
//  MULTU: unsigned 2*WIDTH product. MULT: multiply magnitudes unsigned, negate if signs differ.
//   MULT of (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), exact.
//  Multiply completion: HI/LO load at the MUL->HOLD edge.
//   zflag = (product==0); MULT signflag = product[2W-1]; MULTU signflag = 0.
//  HI/LO hold value across all other ops; only reset clears them.
//  Illegal opcode: completes in 1 cycle, result 0, all flags 0, illegal_op=1. Otherwise illegal_op=0.
//  Reset during MUL or HOLD: immediate return to IDLE; the pending result is never presented.
// STRUCTURE
//  Package alu_pkg: localparams for group codes ARITH=3'b000, LOGIC=3'b001, SHIFT=3'b010, LDST=3'b011.
//   Also function codes: ADD=0, MULTU=1, MULT=2, COMP=3, ADDI=4, COMPI=5, SUB=6;
//   AND=0, XOR=1, OR=2; SLL=0, SRL=1, SRA=4; LD=0, ST=1.
//   Also the state enum (IDLE, MUL, HOLD).
//  Sub-module seq_mult #(WIDTH): start/busy/done, unsigned shift-add, WIDTH iterations, 2W product.
//  Top: handshake FSM, single-cycle datapath, sign correction, flag/HI/LO registers.
// TESTING
//  ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, carry=0, sign=1, zflag=0, out_valid next cycle.
//  ADD 0xFFFFFFFF+1 -> result 0, carry=1, zflag=1, overflow=0.
//  MULT -3 * 5 -> out_valid 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1, sign=1, alu_result=0.
//  MULTU 0xFFFFFFFF*2 -> hi=0x00000001, lo=0xFFFFFFFE.
//  Then XOR -> hi/lo unchanged.
//  Backpressure: out_ready=0 for 5 cycles after SRA 0x80000000 by 31.
//   -> result 0xFFFFFFFF held stable, in_ready=0, no new accept.
//  Stream 4 ANDs with out_ready=1 -> one result per cycle, in order.
//  rst pulse mid-cycle at MUL iteration 10 -> out_valid=0, in_ready=1, hi=lo=0 immediately.
//   Next ADD 2+3 -> 5.
//  alu_op=7'b1110000 -> illegal_op=1, result 0, flags 0, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and flag bundle for the multicycle ALU.
// Opcode layout: [6:4] selects the group, [3:0] the function within it.
package alu_pkg;

    localparam logic [2:0] GRP_ARITH = 3'b000;
    localparam logic [2:0] GRP_LOGIC = 3'b001;
    localparam logic [2:0] GRP_SHIFT = 3'b010;
    localparam logic [2:0] GRP_LDST  = 3'b011;

    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_MULTU = 4'd1;
    localparam logic [3:0] FN_MULT  = 4'd2;
    localparam logic [3:0] FN_COMP  = 4'd3;
    localparam logic [3:0] FN_ADDI  = 4'd4;
    localparam logic [3:0] FN_COMPI = 4'd5;
    localparam logic [3:0] FN_SUB   = 4'd6;

    localparam logic [3:0] FN_AND = 4'd0;
    localparam logic [3:0] FN_XOR = 4'd1;
    localparam logic [3:0] FN_OR  = 4'd2;

    localparam logic [3:0] FN_SLL = 4'd0;
    localparam logic [3:0] FN_SRL = 4'd1;
    localparam logic [3:0] FN_SRA = 4'd4;

    localparam logic [3:0] FN_LD = 4'd0;
    localparam logic [3:0] FN_ST = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic z;
        logic s;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/seq_mult.sv
// Unsigned shift-add multiplier: WIDTH iterations, the first taken on the start edge,
// so done_o is high in the cycle after the final iteration.
module seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, cur_prod, step;
    logic [WIDTH-1:0]   mcand_q, cur_mcand;
    logic [WIDTH:0]     partial;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    // Upper half accumulates, lower half shifts the multiplier out one bit per step.
    assign cur_prod  = start_i ? {{WIDTH{1'b0}}, b_i} : prod_q;
    assign cur_mcand = start_i ? a_i : mcand_q;
    assign partial   = {1'b0, cur_prod[2*WIDTH-1:WIDTH]}
                     + (cur_prod[0] ? {1'b0, cur_mcand} : {(WIDTH+1){1'b0}});
    assign step      = {partial, cur_prod[WIDTH-1:1]};

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            prod_q  <= step;
            mcand_q <= a_i;
            cnt_q   <= CNT_W'(WIDTH - 1);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                prod_q <= step;
                cnt_q  <= cnt_q - CNT_W'(1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == '0);
    assign product_o = prod_q;

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked execute-stage ALU: single-cycle ops register in one cycle, MULT/MULTU
// iterate in seq_mult and land in the HI/LO architectural registers.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zflag,
    output logic             signflag,
    output logic             carryflag,
    output logic             overflowflag,
    output logic             illegal_op,
    output logic [WIDTH-1:0] hi_value,
    output logic [WIDTH-1:0] lo_value
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   result_q, res_d, hi_q, lo_q, a_mag, b_mag;
    flags_t             flags_q, flags_d;
    logic               illegal_q, illegal_d, neg_q, msigned_q;
    logic               is_mul, mul_signed, mul_neg, accept;
    logic               mul_busy, mul_done;
    logic [WIDTH:0]     add_sum, sub_sum;
    logic [2*WIDTH-1:0] mul_prod, mul_final;
    logic [2:0]         grp;
    logic [3:0]         fn;
    logic [SHAMT_W-1:0] shamt;

    assign grp     = alu_op[OP_W-1 -: 3];
    assign fn      = alu_op[3:0];
    assign shamt   = in_b[SHAMT_W-1:0];
    assign add_sum = {1'b0, in_a} + {1'b0, in_b};
    assign sub_sum = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        res_d      = '0;
        flags_d    = '0;
        illegal_d  = 1'b0;
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        case (grp)
            GRP_ARITH: begin
                case (fn)
                    FN_ADD, FN_ADDI: begin
                        res_d     = add_sum[WIDTH-1:0];
                        flags_d.c = add_sum[WIDTH];
                        flags_d.v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_sum[WIDTH-1] != in_a[WIDTH-1]);
                    end
                    FN_SUB: begin
                        res_d     = sub_sum[WIDTH-1:0];
                        flags_d.c = sub_sum[WIDTH];
                        flags_d.v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_sum[WIDTH-1] != in_a[WIDTH-1]);
                    end
                    FN_COMP, FN_COMPI: res_d = -in_b;
                    FN_MULTU: is_mul = 1'b1;
                    FN_MULT: begin
                        is_mul     = 1'b1;
                        mul_signed = 1'b1;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            GRP_LOGIC: begin
                case (fn)
                    FN_AND:  res_d = in_a & in_b;
                    FN_XOR:  res_d = in_a ^ in_b;
                    FN_OR:   res_d = in_a | in_b;
                    default: illegal_d = 1'b1;
                endcase
            end
            GRP_SHIFT: begin
                case (fn)
                    FN_SLL:  res_d = in_a << shamt;
                    FN_SRL:  res_d = in_a >> shamt;
                    FN_SRA:  res_d = $unsigned($signed(in_a) >>> shamt);
                    default: illegal_d = 1'b1;
                endcase
            end
            GRP_LDST: begin
                case (fn)
                    FN_LD, FN_ST: res_d = add_sum[WIDTH-1:0];
                    default:      illegal_d = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
        if (!illegal_d) begin
            flags_d.z = (res_d == '0);
            flags_d.s = res_d[WIDTH-1];
        end
    end

    // Signed multiply runs on magnitudes; the sign is reapplied to the full product.
    assign a_mag     = (mul_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_mag     = (mul_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign mul_neg   = mul_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    assign mul_final = neg_q ? -mul_prod : mul_prod;

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept && is_mul),
        .a_i       (a_mag),
        .b_i       (b_mag),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            msigned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept && is_mul) begin
                        state_q   <= ST_MUL;
                        neg_q     <= mul_neg;
                        msigned_q <= mul_signed;
                    end else if (accept) begin
                        state_q   <= ST_HOLD;
                        result_q  <= res_d;
                        flags_q   <= flags_d;
                        illegal_q <= illegal_d;
                    end else if ((state_q == ST_HOLD) && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q   <= ST_HOLD;
                        hi_q      <= mul_final[2*WIDTH-1:WIDTH];
                        lo_q      <= mul_final[WIDTH-1:0];
                        result_q  <= '0;
                        flags_q   <= '{z: (mul_final == '0), s: msigned_q && mul_final[2*WIDTH-1], c: 1'b0, v: 1'b0};
                        illegal_q <= 1'b0;
                    end else if (!mul_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = (state_q == ST_HOLD);
    assign alu_result   = result_q;
    assign zflag        = flags_q.z;
    assign signflag     = flags_q.s;
    assign carryflag    = flags_q.c;
    assign overflowflag = flags_q.v;
    assign illegal_op   = illegal_q;
    assign hi_value     = hi_q;
    assign lo_value     = lo_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: vector table for single-cycle ops, hand sequences
// for multiply latency, HI/LO retention, backpressure, streaming and mid-multiply reset.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  alu_op;
    logic [31:0] in_a, in_b, alu_result, hi_value, lo_value;
    logic        zflag, signflag, carryflag, overflowflag, illegal_op;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;   // {z, s, c, v, illegal}
    } vec_t;

    vec_t vecs[21];

    multicycle_alu #(.WIDTH(32), .OP_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_result   (alu_result),
        .zflag        (zflag),
        .signflag     (signflag),
        .carryflag    (carryflag),
        .overflowflag (overflowflag),
        .illegal_op   (illegal_op),
        .hi_value     (hi_value),
        .lo_value     (lo_value)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        in_a     = a;
        in_b     = b;
    endtask

    function automatic logic [4:0] flags_now();
        return {zflag, signflag, carryflag, overflowflag, illegal_op};
    endfunction

    task automatic run_mul(input string name, input logic [6:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic [4:0] exp_flg);
        int lat;
        drive(op, a, b);
        tick();
        in_valid = 1'b0;
        check({name, "_ready_busy"}, in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 33);
        check({name, "_hi"}, hi_value, exp_hi);
        check({name, "_lo"}, lo_value, exp_lo);
        check({name, "_flags"}, flags_now(), exp_flg);
        check({name, "_result"}, alu_result, 0);
        tick();
    endtask

    initial begin
        logic [31:0] sa[4];
        logic [31:0] sb[4];
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; in_a = '0; in_b = '0;

        vecs[0]  = '{"add_ovf",    7'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010};
        vecs[1]  = '{"add_carry",  7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100};
        vecs[2]  = '{"addi",       7'h04, 32'h00000005, 32'h00000003, 32'h00000008, 5'b00000};
        vecs[3]  = '{"sub_pos",    7'h06, 32'h00000005, 32'h00000003, 32'h00000002, 5'b00100};
        vecs[4]  = '{"sub_borrow", 7'h06, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 5'b01000};
        vecs[5]  = '{"sub_ovf",    7'h06, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110};
        vecs[6]  = '{"comp",       7'h03, 32'h12345678, 32'h00000005, 32'hFFFFFFFB, 5'b01000};
        vecs[7]  = '{"compi_zero", 7'h05, 32'h00001234, 32'h00000000, 32'h00000000, 5'b10000};
        vecs[8]  = '{"and",        7'h10, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000};
        vecs[9]  = '{"xor",        7'h11, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 5'b00000};
        vecs[10] = '{"or_zero",    7'h12, 32'h00000000, 32'h00000000, 32'h00000000, 5'b10000};
        vecs[11] = '{"sll_31",     7'h20, 32'h00000001, 32'h0000001F, 32'h80000000, 5'b01000};
        vecs[12] = '{"sll_shamt",  7'h20, 32'h00000003, 32'h00000024, 32'h00000030, 5'b00000};
        vecs[13] = '{"srl",        7'h21, 32'h80000000, 32'h00000004, 32'h08000000, 5'b00000};
        vecs[14] = '{"sra_neg",    7'h24, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000};
        vecs[15] = '{"sra_pos",    7'h24, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 5'b10000};
        vecs[16] = '{"ldaddr",     7'h30, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000};
        vecs[17] = '{"staddr",     7'h31, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01000};
        vecs[18] = '{"illegal_grp",7'h70, 32'h00000005, 32'h00000005, 32'h00000000, 5'b00001};
        vecs[19] = '{"illegal_ar", 7'h07, 32'h00000001, 32'h00000001, 32'h00000000, 5'b00001};
        vecs[20] = '{"illegal_lg", 7'h13, 32'h0000000F, 32'h0000000F, 32'h00000000, 5'b00001};

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", alu_result, 0);
        check("rst_flags", flags_now(), 0);
        check("rst_hi", hi_value, 0);
        check("rst_lo", lo_value, 0);
        #10 rst = 1'b0;
        tick();

        // Single-cycle vectors, back to back
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check({vecs[i].name, "_result"}, alu_result, vecs[i].res);
            check({vecs[i].name, "_flags"}, flags_now(), vecs[i].flg);
        end
        in_valid = 1'b0;
        tick();
        check("idle_after_table", out_valid, 0);

        // Multiplies
        run_mul("mult_neg",   7'h02, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5'b01000);
        run_mul("mult_min",   7'h02, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5'b00000);
        run_mul("mult_zero",  7'h02, 32'h00000000, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 5'b10000);
        run_mul("multu_max",  7'h01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5'b00000);

        // HI/LO survive a later single-cycle op
        drive(7'h11, 32'hAAAA0000, 32'h0000AAAA);
        tick();
        in_valid = 1'b0;
        check("xor_after_mul_result", alu_result, 32'hAAAAAAAA);
        check("xor_hi_kept", hi_value, 32'h00000001);
        check("xor_lo_kept", lo_value, 32'hFFFFFFFE);
        tick();

        // Backpressure: SRA result held for 5 cycles while another op is offered
        out_ready = 1'b0;
        drive(7'h24, 32'h80000000, 32'h0000001F);
        tick();
        drive(7'h00, 32'h00000001, 32'h00000001);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_result", alu_result, 32'hFFFFFFFF);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_next_result", alu_result, 32'h00000002);
        tick();

        // Stream of four ANDs at one per cycle
        sa = '{32'hFFFFFFFF, 32'h12345678, 32'hF0F0F0F0, 32'h0000FFFF};
        sb = '{32'h0000000F, 32'hFFFF0000, 32'h33333333, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            drive(7'h10, sa[i], sb[i]);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_result", alu_result, sa[i] & sb[i]);
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a multiply
        drive(7'h02, 32'h00000007, 32'h00000009);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #3 rst = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_hi", hi_value, 0);
        check("mrst_lo", lo_value, 0);
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_stale_result", seen, 0);
        drive(7'h00, 32'h00000002, 32'h00000003);
        tick();
        in_valid = 1'b0;
        check("mrst_add_valid", out_valid, 1);
        check("mrst_add_result", alu_result, 32'h00000005);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
